maze_button_conditioner: RTL
============================

Name: maze_button_conditioner

Overview:
Front-end stage feeding the maze game controller. It takes the five raw board push-buttons (control, up, down, left, right) and turns them into clean signals the controller can use directly:
- synchronises each button to clk;
- debounces each button;
- emits single-cycle press pulses, with optional auto-repeat on held direction buttons.

Direction pulses are arbitrated so at most one direction pulse is asserted per cycle.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
DEBOUNCE_CYCLES, 500000, consecutive equal samples required to accept a level change (5 ms at 100 MHz).
REPEAT_EN, 1, 1 = auto-repeat on held direction buttons; 0 = a press gives one pulse only.
REPEAT_DELAY, 30000000, cycles from the accepted press pulse to the first repeat pulse.
REPEAT_RATE, 10000000, cycles between subsequent repeat pulses.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
i_btn_control  input  1  raw control button, asynchronous to clk.
i_btn_up  input  1  raw up button.
i_btn_down  input  1  raw down button.
i_btn_left  input  1  raw left button.
i_btn_right  input  1  raw right button.
o_control  output  1  one-cycle pulse on a debounced control press.
o_up  output  1  one-cycle up pulse (press or repeat).
o_down  output  1  one-cycle down pulse.
o_left  output  1  one-cycle left pulse.
o_right  output  1  one-cycle right pulse.
o_held  output  5  debounced levels {control, up, down, left, right}, for LEDs/debug.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high. All flops clear on rst assertion.
- Reset values: all pulse outputs 0, o_held = 5'b0, synchronisers 0, counters 0, FSMs in their idle state.
- Button held through reset: reads as a new press after release (one pulse after the full latency).
- Synchroniser: per button, a chain of SYNC_STAGES flops. Only the last stage is used downstream.
- Debounce FSM, per button, states:
  - S_LOW: debounced 0. Sync input 1 -> S_WAIT_HIGH with count = 1.
  - S_WAIT_HIGH: input 1 -> count+1; input 0 -> back to S_LOW, count = 0. When count reaches DEBOUNCE_CYCLES -> S_HIGH, debounced = 1.
  - S_HIGH: debounced 1. Input 0 -> S_WAIT_LOW with count = 1.
  - S_WAIT_LOW: mirror of S_WAIT_HIGH, returning to S_HIGH on a bounce.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- Edge detect: a press event occurs when debounced goes 0->1. Release generates nothing.
- Latency: for a clean raw rising edge held stable, the pulse is asserted exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges after the first edge that samples raw high. Pulse width is exactly 1 cycle.
- Control path: the press event is registered to o_control. No repeat.
- Direction arbiter: fixed priority up > down > left > right.
  - Simultaneous press events in one cycle: only the highest-priority one is accepted; the others are discarded (no deferred pulse).
  - The accepted press becomes the active direction.
- Repeat FSM (single instance, tracks the active direction), states:
  - R_IDLE: on an accepted press -> emit pulse, timer = 0, go to R_DELAY.
  - R_DELAY: timer counts to REPEAT_DELAY-1, then emits a pulse -> R_REPEAT with timer = 0.
  - R_REPEAT: emits a pulse every REPEAT_RATE cycles.
  - Active button's debounced level falls -> R_IDLE immediately; no pulse that cycle.
  - New accepted press on a different direction while in R_DELAY or R_REPEAT: the active direction switches, its press pulse is emitted, timer restarts in R_DELAY.
  - Repeat pulse and new press due in the same cycle: the new press wins; only one pulse is emitted.
  - REPEAT_EN = 0: the FSM never leaves R_IDLE beyond emitting the press pulse.
- Timer width: $clog2(max(REPEAT_DELAY, REPEAT_RATE)+1).
- Invariant: at most one of o_up/o_down/o_left/o_right is high in any cycle. o_control is independent and may coincide with a direction pulse.
- Reset mid-operation: rst asserted during a wait or repeat immediately clears all outputs. No pulse is emitted on rst deassertion.

Decomposition:
- maze_pkg:
  - debounce state enum {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW};
  - repeat state enum {R_IDLE, R_DELAY, R_REPEAT};
  - direction index constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
- Sub-module maze_debounce: one button, containing synchroniser + debounce FSM + rising-edge flag. Parameters SYNC_STAGES, DEBOUNCE_CYCLES.
- The top level instantiates maze_debounce five times and contains the arbiter and the repeat FSM.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
1. Clean up press: raw up high at edge 0, held 10 cycles, REPEAT_EN=0 -> o_up high for exactly 1 cycle at edge 7; o_held[3] high from edge 6; no further pulses.
2. Bounce: raw left toggles 1,1,0,1,1,1,1 then held -> counter restarts on the 0; a single o_left pulse 7 edges after the last 0->1 transition.
3. Auto-repeat: right held 60 cycles, REPEAT_EN=1 -> pulses at press edge P, then P+20, P+28, P+36, P+44, P+52; release -> no more pulses.
4. Simultaneous: raw up and down rise on the same edge -> only o_up pulses; o_down stays 0 for the whole hold. Releasing up with down still held gives no down pulse.
5. Direction switch: hold up, then press left at P+12 -> o_left press pulse; left repeats resume 20 cycles later; no o_up repeats after the switch.
6. Async reset mid-repeat: assert rst at an arbitrary sub-cycle time during R_REPEAT -> all outputs 0 immediately. After release with right still held -> one o_right pulse at 7 edges after release, then the repeat schedule.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze game button front-end.
package maze_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } db_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rep_state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Lowest direction index wins: up > down > left > right.
  function automatic logic [1:0] dir_priority(input logic [3:0] i_req);
    logic [1:0] v_sel;
    v_sel = DIR_RIGHT;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[i]) v_sel = 2'(i);
    end
    return v_sel;
  endfunction

endpackage

// File: rtl/maze_debounce.sv
// One button: synchroniser chain, debounce FSM and rising-edge flag.
module maze_debounce
  import maze_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_in;
  db_state_t              r_state;
  db_state_t              w_state_nxt;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_nxt;
  logic                   r_level;
  logic                   w_level_nxt;
  logic                   r_level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
  end

  assign w_in = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_LOW;
      r_count   <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_level   <= w_level_nxt;
      r_level_d <= r_level;
    end
  end

  // Count stays below DEBOUNCE_CYCLES before advancing, so it saturates rather than wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_level_nxt = r_level;
    case (r_state)
      S_LOW: begin
        if (w_in) begin
          w_state_nxt = S_WAIT_HIGH;
          w_count_nxt = CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (!w_in) begin
          w_state_nxt = S_LOW;
          w_count_nxt = '0;
        end else if (r_count >= CW'(DEBOUNCE_CYCLES)) begin
          w_state_nxt = S_HIGH;
          w_count_nxt = '0;
          w_level_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      S_HIGH: begin
        if (!w_in) begin
          w_state_nxt = S_WAIT_LOW;
          w_count_nxt = CW'(1);
        end
      end
      S_WAIT_LOW: begin
        if (w_in) begin
          w_state_nxt = S_HIGH;
          w_count_nxt = '0;
        end else if (r_count >= CW'(DEBOUNCE_CYCLES)) begin
          w_state_nxt = S_LOW;
          w_count_nxt = '0;
          w_level_nxt = 1'b0;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_count_nxt = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign o_level  = r_level;
  assign o_rise_c = r_level & ~r_level_d;

endmodule

// File: rtl/maze_button_conditioner.sv
// Five debounced buttons; control press pulse plus arbitrated, auto-repeating direction pulses.
module maze_button_conditioner
  import maze_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 30000000,
  parameter int unsigned REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_control,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  output logic       o_control,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic [4:0] o_held
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  logic [4:0]    w_raw;
  logic [4:0]    w_level;
  logic [4:0]    w_rise;
  logic [3:0]    w_dir_rise;
  logic [3:0]    w_dir_level;
  logic [1:0]    w_sel;

  rep_state_t    r_rstate;
  rep_state_t    w_rstate_nxt;
  logic [1:0]    r_active;
  logic [1:0]    w_active_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [3:0]    r_pulse;
  logic [3:0]    w_pulse_nxt;
  logic          r_control;

  assign w_raw = {i_btn_control, i_btn_up, i_btn_down, i_btn_left, i_btn_right};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    maze_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (w_raw[gi]),
      .o_level  (w_level[gi]),
      .o_rise_c (w_rise[gi])
    );
  end

  // Re-index the held-order vectors into direction order.
  always_comb begin
    w_dir_rise             = '0;
    w_dir_level            = '0;
    w_dir_rise[DIR_UP]     = w_rise[3];
    w_dir_rise[DIR_DOWN]   = w_rise[2];
    w_dir_rise[DIR_LEFT]   = w_rise[1];
    w_dir_rise[DIR_RIGHT]  = w_rise[0];
    w_dir_level[DIR_UP]    = w_level[3];
    w_dir_level[DIR_DOWN]  = w_level[2];
    w_dir_level[DIR_LEFT]  = w_level[1];
    w_dir_level[DIR_RIGHT] = w_level[0];
  end

  assign w_sel = dir_priority(w_dir_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_active  <= DIR_UP;
      r_timer   <= '0;
      r_pulse   <= '0;
      r_control <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_active  <= w_active_nxt;
      r_timer   <= w_timer_nxt;
      r_pulse   <= w_pulse_nxt;
      r_control <= w_rise[4];
    end
  end

  // A new press always pre-empts a repeat due in the same cycle.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_active_nxt = r_active;
    w_timer_nxt  = r_timer;
    w_pulse_nxt  = '0;
    if (|w_dir_rise) begin
      w_pulse_nxt[w_sel] = 1'b1;
      w_active_nxt       = w_sel;
      w_timer_nxt        = '0;
      w_rstate_nxt       = (REPEAT_EN != 0) ? R_DELAY : R_IDLE;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          w_timer_nxt = '0;
        end
        R_DELAY: begin
          if (!w_dir_level[r_active]) begin
            w_rstate_nxt = R_IDLE;
          end else if (r_timer == TW'(REPEAT_DELAY - 1)) begin
            w_pulse_nxt[r_active] = 1'b1;
            w_rstate_nxt          = R_REPEAT;
            w_timer_nxt           = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        R_REPEAT: begin
          if (!w_dir_level[r_active]) begin
            w_rstate_nxt = R_IDLE;
          end else if (r_timer == TW'(REPEAT_RATE - 1)) begin
            w_pulse_nxt[r_active] = 1'b1;
            w_timer_nxt           = '0;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
          w_rstate_nxt = R_IDLE;
        end
      endcase
    end
  end

  assign o_control = r_control;
  assign o_up      = r_pulse[DIR_UP];
  assign o_down    = r_pulse[DIR_DOWN];
  assign o_left    = r_pulse[DIR_LEFT];
  assign o_right   = r_pulse[DIR_RIGHT];
  assign o_held    = w_level;

endmodule
